// File: rtl/read_channel_distributer.sv
// Routes SRAM read beats to one of num_of_ports single-entry output slots.
// Optional misroute flag err_sticky is built only when DIST_ERR_EN is defined.
module read_channel_distributer #(
  parameter int num_of_ports       = 16,
  parameter int arbiter_data_width = 256
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [arbiter_data_width-1:0]              in_data,
  input  logic [3:0]                                 in_port,
  output logic [arbiter_data_width*num_of_ports-1:0] out_data,
  output logic [num_of_ports-1:0]                    out_valid,
  input  logic [num_of_ports-1:0]                    out_ready,
  output logic [3:0]                                 last_port
`ifdef DIST_ERR_EN
  ,
  output logic                                       err_sticky
`endif
);

  localparam int N = num_of_ports;
  localparam int W = arbiter_data_width;

  logic [N-1:0]        port_sel;
  logic                in_range;
  logic                slot_open;
  logic                accept;
  logic [N-1:0]        drain;
  logic [N-1:0]        load;

  logic [N-1:0]        full_d,      full_q;
  logic [N-1:0][W-1:0] data_d,      data_q;
  logic [3:0]          last_port_d, last_port_q;

  // One-hot decode of the destination; an out-of-range index selects nothing.
  always_comb begin
    port_sel = '0;
    for (int i = 0; i < N; i++) begin
      port_sel[i] = (in_port == 4'(i));
    end
  end

  assign in_range  = |port_sel;
  // A slot can take a beat when it is empty or is being drained this cycle.
  assign slot_open = |(port_sel & (~full_q | out_ready));
  assign in_ready  = !rst && (!in_range || slot_open);
  assign accept    = in_valid && in_ready;

  assign drain = full_q & out_ready;
  assign load  = {N{accept}} & port_sel;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      if (load[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end else if (drain[i]) begin
        full_d[i] = 1'b0;
        data_d[i] = '0;
      end
    end
  end

  always_comb begin
    last_port_d = last_port_q;
    if (accept) begin
      last_port_d = in_port;
    end
  end

  // NOTE: the data slots are reset too, because an empty slot must present all zeros.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      data_q      <= '0;
      last_port_q <= '0;
    end else begin
      full_q      <= full_d;
      data_q      <= data_d;
      last_port_q <= last_port_d;
    end
  end

`ifdef DIST_ERR_EN
  logic err_sticky_d, err_sticky_q;

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (accept && !in_range) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign last_port = last_port_q;

endmodule

// File: tb/tb_read_channel_distributer.sv
// Directed self-checking bench for read_channel_distributer (8 ports, 32-bit beats).
// Checks err_sticky as well when DIST_ERR_EN is defined.
module tb_read_channel_distributer;

  localparam int N = 8;
  localparam int W = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [3:0]       in_port;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [3:0]       last_port;
`ifdef DIST_ERR_EN
  logic             err_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [N*W-1:0] exp_data;

  read_channel_distributer #(
    .num_of_ports      (N),
    .arbiter_data_width(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_port  (in_port),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last_port(last_port)
`ifdef DIST_ERR_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_port = 4'd3; in_data = 32'hDEADBEEF; out_ready = '0;
    #2;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL rst_valid: got %h want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_checks++; if (last_port !== 4'd0) begin n_fail++; $display("FAIL rst_last_port: got %0d want 0", last_port); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
`ifdef DIST_ERR_EN
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_sticky); end
`endif
    tick();
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL rst_no_xfer: got %h want 0", out_valid); end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    in_valid = 1'b1; in_port = 4'd3; in_data = 32'hA5A5A5A5; out_ready = '0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    exp_data = '0; exp_data[3*W +: W] = 32'hA5A5A5A5;
    n_checks++; if (out_valid !== 8'h08) begin n_fail++; $display("FAIL single_valid: got %h want 08", out_valid); end
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, exp_data); end
    n_checks++; if (last_port !== 4'd3) begin n_fail++; $display("FAIL single_last_port: got %0d want 3", last_port); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_port = 4'd3; in_data = 32'h5A5A5A5A; out_ready = '0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    tick();
    exp_data = '0; exp_data[3*W +: W] = 32'hA5A5A5A5;
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", out_data, exp_data); end
    n_checks++; if (out_valid !== 8'h08) begin n_fail++; $display("FAIL bp_hold_valid: got %h want 08", out_valid); end
    out_ready = 8'h08;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_drain: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = '0;
    exp_data = '0; exp_data[3*W +: W] = 32'h5A5A5A5A;
    n_checks++; if (out_valid !== 8'h08) begin n_fail++; $display("FAIL bp_refill_valid: got %h want 08", out_valid); end
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL bp_refill_data: got %h want %h", out_data, exp_data); end
    out_ready = 8'h08;
    tick();
    out_ready = '0;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL bp_drain_valid: got %h want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL bp_drain_zero: got %h want 0", out_data); end
  endtask

  task automatic test_back_to_back();
    out_ready = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_port = 4'(k); in_data = 32'h1000 + 32'(k);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
      tick();
      exp_data = '0; exp_data[k*W +: W] = 32'h1000 + 32'(k);
      n_checks++; if (out_valid !== 8'(1 << k)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %h want %h", k, out_valid, 8'(1 << k)); end
      n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, out_data, exp_data); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = '0;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL b2b_empty: got %h want 0", out_valid); end
    n_checks++; if (last_port !== 4'd2) begin n_fail++; $display("FAIL b2b_last_port: got %0d want 2", last_port); end
  endtask

  task automatic test_independent();
    in_valid = 1'b1; in_port = 4'd1; in_data = 32'h11111111;
    tick();
    in_port = 4'd6; in_data = 32'h66666666;
    tick();
    in_port = 4'd4; in_data = 32'h44444444; out_ready = 8'h02;
    tick();
    in_valid = 1'b0; out_ready = '0;
    exp_data = '0;
    exp_data[4*W +: W] = 32'h44444444;
    exp_data[6*W +: W] = 32'h66666666;
    n_checks++; if (out_valid !== 8'h50) begin n_fail++; $display("FAIL indep_valid: got %h want 50", out_valid); end
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL indep_data: got %h want %h", out_data, exp_data); end
    n_checks++; if (last_port !== 4'd4) begin n_fail++; $display("FAIL indep_last_port: got %0d want 4", last_port); end
  endtask

  task automatic test_discard();
    in_valid = 1'b1; in_port = 4'd12; in_data = 32'hCCCCCCCC;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL disc_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; in_port = 4'd0;
    n_checks++; if (out_valid !== 8'h50) begin n_fail++; $display("FAIL disc_valid: got %h want 50", out_valid); end
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL disc_data: got %h want %h", out_data, exp_data); end
    n_checks++; if (last_port !== 4'd12) begin n_fail++; $display("FAIL disc_last_port: got %0d want 12", last_port); end
`ifdef DIST_ERR_EN
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL disc_err_set: got %b want 1", err_sticky); end
    tick(); tick();
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL disc_err_hold: got %b want 1", err_sticky); end
`endif
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_port = 4'd2; in_data = 32'h22222222;
    tick();
    in_port = 4'd5; in_data = 32'h55555555;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 8'h74) begin n_fail++; $display("FAIL ar_pre_valid: got %h want 74", out_valid); end
    #2;
    rst = 1'b1; in_valid = 1'b1; in_port = 4'd2; in_data = 32'h77777777;
    #1;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL ar_valid: got %h want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL ar_data: got %h want 0", out_data); end
    n_checks++; if (last_port !== 4'd0) begin n_fail++; $display("FAIL ar_last_port: got %0d want 0", last_port); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_in_ready: got %b want 0", in_ready); end
`ifdef DIST_ERR_EN
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", err_sticky); end
`endif
    tick();
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL ar_no_xfer: got %h want 0", out_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_after: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    exp_data = '0; exp_data[2*W +: W] = 32'h77777777;
    n_checks++; if (out_valid !== 8'h04) begin n_fail++; $display("FAIL ar_first_accept: got %h want 04", out_valid); end
    n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL ar_first_data: got %h want %h", out_data, exp_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_independent();
    test_discard();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
